// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-at-a-time imem requests, valid/ready delivery to decode.
// Optional IFETCH_STAT_EN adds transfer/drop counters (stat_fetch_o, stat_drop_o).
module instr_fetch #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_valid_i,
    input  logic [31:0]     imem_data_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [PC_W-1:0] instr_pc_o,
    output logic [5:0]      instr_op_o
`ifdef IFETCH_STAT_EN
    ,
    output logic [31:0]     stat_fetch_o,
    output logic [31:0]     stat_drop_o
`endif
);

    typedef enum logic [1:0] {StFetch, StWait, StHold, StDrop} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            // A request issued alongside a redirect is still answered, so drain it.
            StFetch: state_d = redirect_i ? StDrop : StWait;
            StWait: begin
                if (redirect_i) begin
                    state_d = imem_valid_i ? StFetch : StDrop;
                end else if (imem_valid_i) begin
                    instr_d    = imem_data_i;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + PC_W'(4);
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (redirect_i || instr_ready_i) begin
                    state_d = StFetch;
                end
            end
            StDrop: begin
                if (imem_valid_i) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
        if (redirect_i) begin
            pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
        end
    end

    // Reset state is FETCH, so the request is gated to keep outputs quiet while in reset.
    assign imem_req_o    = (state_q == StFetch) && rst_i;
    assign imem_addr_o   = imem_req_o ? pc_q : '0;
    assign instr_valid_o = (state_q == StHold);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_op_o    = instr_q[31:26];

`ifdef IFETCH_STAT_EN
    logic [31:0] stat_fetch_q, stat_drop_q;
    logic        fetch_evt, drop_evt;

    assign fetch_evt = (state_q == StHold) && instr_ready_i && !redirect_i;
    assign drop_evt  = imem_valid_i &&
                       ((state_q == StDrop) || ((state_q == StWait) && redirect_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_fetch_q <= '0;
            stat_drop_q  <= '0;
        end else begin
            if (fetch_evt) stat_fetch_q <= stat_fetch_q + 32'd1;
            if (drop_evt)  stat_drop_q  <= stat_drop_q + 32'd1;
        end
    end

    assign stat_fetch_o = stat_fetch_q;
    assign stat_drop_o  = stat_drop_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; memory responses are driven by hand.
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [5:0]  instr_op_o;
`ifdef IFETCH_STAT_EN
    logic [31:0] stat_fetch_o;
    logic [31:0] stat_drop_o;
`endif

    int total = 0;
    int bad   = 0;

    instr_fetch #(
        .PC_W     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_valid_i  (imem_valid_i),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_op_o    (instr_op_o)
`ifdef IFETCH_STAT_EN
        ,
        .stat_fetch_o  (stat_fetch_o),
        .stat_drop_o   (stat_drop_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_req"},   32'(imem_req_o),    32'd0);
        check_val({tag, "_addr"},  imem_addr_o,        32'd0);
        check_val({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
        check_val({tag, "_instr"}, instr_o,            32'd0);
        check_val({tag, "_pc"},    instr_pc_o,         32'd0);
        check_val({tag, "_op"},    32'(instr_op_o),    32'd0);
    endtask

    initial begin
        rst_i         = 1'b0;
        imem_valid_i  = 1'b0;
        imem_data_i   = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");

        // Basic fetch with 1-cycle memory.
        rst_i = 1'b1;
        #1;
        check_val("t1_req",  32'(imem_req_o), 32'd1);
        check_val("t1_addr", imem_addr_o,     32'h0);
        tick();
        check_val("t1_wait_req", 32'(imem_req_o), 32'd0);
        imem_valid_i = 1'b1;
        imem_data_i  = 32'h2008_0005;
        tick();
        imem_valid_i = 1'b0;
        check_val("t1_valid", 32'(instr_valid_o), 32'd1);
        check_val("t1_op",    32'(instr_op_o),    32'h08);
        check_val("t1_pc",    instr_pc_o,         32'h0);
        check_val("t1_instr", instr_o,            32'h2008_0005);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        check_val("t1_next_req",  32'(imem_req_o),    32'd1);
        check_val("t1_next_addr", imem_addr_o,        32'h4);
        check_val("t1_valid_clr", 32'(instr_valid_o), 32'd0);
`ifdef IFETCH_STAT_EN
        check_val("t1_stat_fetch", stat_fetch_o, 32'd1);
`endif

        // Decode stalls for 5 cycles in HOLD.
        tick();
        imem_valid_i = 1'b1;
        imem_data_i  = 32'h8C01_0004;
        tick();
        imem_valid_i = 1'b0;
        imem_data_i  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            check_val("t2_valid", 32'(instr_valid_o), 32'd1);
            check_val("t2_instr", instr_o,            32'h8C01_0004);
            check_val("t2_pc",    instr_pc_o,         32'h4);
            check_val("t2_req",   32'(imem_req_o),    32'd0);
            tick();
        end
        check_val("t2_op", 32'(instr_op_o), 32'h23);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        check_val("t2_next_addr", imem_addr_o, 32'h8);

        // Latency 3 with a redirect one cycle after the request.
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        check_val("t3_drop_req",   32'(imem_req_o),    32'd0);
        check_val("t3_drop_valid", 32'(instr_valid_o), 32'd0);
        tick();
        check_val("t3_drop_req2", 32'(imem_req_o), 32'd0);
        imem_valid_i = 1'b1;
        imem_data_i  = 32'h1234_5678;
        tick();
        imem_valid_i = 1'b0;
        check_val("t3_req",   32'(imem_req_o),    32'd1);
        check_val("t3_addr",  imem_addr_o,        32'h40);
        check_val("t3_valid", 32'(instr_valid_o), 32'd0);
        check_val("t3_instr_kept", instr_o,       32'h8C01_0004);
`ifdef IFETCH_STAT_EN
        check_val("t3_stat_drop", stat_drop_o, 32'd1);
`endif

        // Redirect to an unaligned target together with ready in HOLD.
        tick();
        imem_valid_i = 1'b1;
        imem_data_i  = 32'h0000_0020;
        tick();
        imem_valid_i = 1'b0;
        check_val("t4_valid", 32'(instr_valid_o), 32'd1);
        check_val("t4_pc",    instr_pc_o,         32'h40);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h43;
        instr_ready_i = 1'b1;
        tick();
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        check_val("t4_valid_clr", 32'(instr_valid_o), 32'd0);
        check_val("t4_req",       32'(imem_req_o),    32'd1);
        check_val("t4_addr",      imem_addr_o,        32'h40);
`ifdef IFETCH_STAT_EN
        check_val("t4_stat_fetch", stat_fetch_o, 32'd2);
`endif

        // Redirect during FETCH drains the issued request, then PC wraps past the top.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        check_val("t5_drop_req", 32'(imem_req_o), 32'd0);
        imem_valid_i = 1'b1;
        imem_data_i  = 32'hAAAA_5555;
        tick();
        imem_valid_i = 1'b0;
        check_val("t5_addr", imem_addr_o, 32'hFFFF_FFFC);
`ifdef IFETCH_STAT_EN
        check_val("t5_stat_drop", stat_drop_o, 32'd2);
`endif
        tick();
        imem_valid_i = 1'b1;
        imem_data_i  = 32'h0800_0000;
        tick();
        imem_valid_i = 1'b0;
        check_val("t5_pc", instr_pc_o,         32'hFFFF_FFFC);
        check_val("t5_op", 32'(instr_op_o),    32'h02);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        check_val("t5_wrap_req",  32'(imem_req_o), 32'd1);
        check_val("t5_wrap_addr", imem_addr_o,     32'h0);

        // Reset asserted in WAIT; late response after release must not be delivered.
        tick();
        rst_i = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        tick();
        rst_i = 1'b1;
        #1;
        check_val("t6_req",  32'(imem_req_o), 32'd1);
        check_val("t6_addr", imem_addr_o,     32'h0);
        imem_valid_i = 1'b1;
        imem_data_i  = 32'hDEAD_BEEF;
        tick();
        imem_valid_i = 1'b0;
        check_val("t6_late_valid", 32'(instr_valid_o), 32'd0);
        check_val("t6_late_instr", instr_o,            32'd0);
        tick();
        check_val("t6_wait_valid", 32'(instr_valid_o), 32'd0);
        imem_valid_i = 1'b1;
        imem_data_i  = 32'h2008_0005;
        tick();
        imem_valid_i = 1'b0;
        check_val("t6_valid", 32'(instr_valid_o), 32'd1);
        check_val("t6_instr", instr_o,            32'h2008_0005);
        check_val("t6_pc",    instr_pc_o,         32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
